ysyx_24120013_ifu_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of the IDU. Owns the fetch PC and issues one read per

---
 rtl/ysyx_24120013_ifu_fetch.sv | 137 +++++++++++++
 tb/tb_ysyx_24120013_ifu_fetch.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24120013_ifu_fetch.sv
// Instruction fetch stage: owns the fetch PC, issues one memory read at a time, buffers returned words for the IDU.
// Latency: first request 1 cycle after reset release; a response in cycle N is visible to the IDU in cycle N+1.
// Backpressure: stops issuing while the buffer (counting the outstanding read) is full; a request is held until mem_req_ready.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   jmp_en, jmp_pc            redirect pulse and target (low two bits ignored)
//   mem_req_*                 read request channel (valid/ready, word-aligned address)
//   mem_rsp_*                 read response (valid, data, access fault)
//   inst_valid/inst_ready     handshake to the IDU; inst, inst_pc, inst_err describe the buffer head
module ysyx_24120013_ifu_fetch #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000,
  parameter int                    FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jmp_en,
  input  logic [ADDR_WIDTH-1:0] jmp_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic                  inst_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  redirect_seen;   // a redirect hit while the request was still waiting for acceptance

  logic [DATA_WIDTH-1:0] buf_inst [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] buf_pc   [FIFO_DEPTH];
  logic                  buf_err  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W:0]        fifo_count;

  logic [ADDR_WIDTH-1:0] jmp_target;
  logic                  push;
  logic                  pop;

  assign jmp_target = jmp_pc & ~ADDR_WIDTH'(3);

  // The matching request is always mem_req_addr, which is held after the handshake.
  assign push = (state == WAIT) && mem_rsp_valid && !jmp_en;
  assign pop  = inst_valid && inst_ready;

  // Suppress handoff in the redirect cycle: the head belongs to the old path.
  assign inst_valid = (fifo_count != '0) && !jmp_en;
  assign inst       = buf_inst[rd_ptr];
  assign inst_pc    = buf_pc[rd_ptr];
  assign inst_err   = buf_err[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= '0;
      redirect_seen <= 1'b0;
    end else begin
      if (jmp_en) fetch_pc <= jmp_target;
      case (state)
        IDLE: begin
          // No read is outstanding here, so the occupancy alone is the space check.
          if (!jmp_en && (fifo_count < FULL_COUNT)) begin
            state         <= REQ;
            mem_req_valid <= 1'b1;
            mem_req_addr  <= fetch_pc;
            fetch_pc      <= fetch_pc + ADDR_WIDTH'(4);
            redirect_seen <= 1'b0;
          end
        end
        REQ: begin
          // A request is never withdrawn; a redirect only marks its response as stale.
          if (jmp_en) redirect_seen <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= (jmp_en || redirect_seen) ? DROP : WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid)  state <= IDLE;
          else if (jmp_en)    state <= DROP;
        end
        DROP: begin
          if (mem_rsp_valid)  state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        buf_inst[i] <= '0;
        buf_pc[i]   <= '0;
        buf_err[i]  <= 1'b0;
      end
    end else if (jmp_en) begin
      // Redirect wins over any push or pop in the same cycle.
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        buf_inst[wr_ptr] <= mem_rsp_err ? '0 : mem_rsp_data;
        buf_pc[wr_ptr]   <= mem_req_addr;
        buf_err[wr_ptr]  <= mem_rsp_err;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24120013_ifu_fetch.sv
module tb_ysyx_24120013_ifu_fetch;

  logic        clk;
  logic        rst;
  logic        jmp_en;
  logic [31:0] jmp_pc;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        mem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;

  ysyx_24120013_ifu_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .jmp_en        (jmp_en),
    .jmp_pc        (jmp_pc),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .mem_rsp_err   (mem_rsp_err),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] hs_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_inst_q[$];
  logic [31:0] pop_err_q[$];
  logic [31:0] err_addr;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a negedge: record handshakes and pops, cross the rising edge,
  // then drive default inputs (1-cycle memory answers the recorded handshake).
  task automatic edge_drive();
    logic        hs;
    logic [31:0] hs_addr;
    hs      = (mem_req_valid === 1'b1) && (mem_req_ready === 1'b1) && (rst === 1'b0);
    hs_addr = mem_req_addr;
    if (hs) hs_q.push_back(hs_addr);
    if ((inst_valid === 1'b1) && (inst_ready === 1'b1) && (rst === 1'b0)) begin
      pop_pc_q.push_back(inst_pc);
      pop_inst_q.push_back(inst);
      pop_err_q.push_back({31'd0, inst_err});
    end
    @(posedge clk);
    #1;
    jmp_en        = 1'b0;
    mem_rsp_valid = hs;
    mem_rsp_data  = hs ? mdata(hs_addr) : 32'd0;
    mem_rsp_err   = hs && (hs_addr == err_addr);
  endtask

  task automatic to_neg();
    @(negedge clk);
  endtask

  task automatic cyc();
    edge_drive();
    to_neg();
  endtask

  // Leaves time just after the edge that starts cycle 0 (reset released).
  task automatic do_reset();
    rst = 1'b1;
    err_addr = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_req_addr", mem_req_addr, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_err", {31'd0, inst_err}, 32'd0);
    hs_q.delete();
    pop_pc_q.delete();
    pop_inst_q.delete();
    pop_err_q.delete();
    edge_drive();
    rst = 1'b0;
  endtask

  // Returns just after the edge following the n-th handshake, so the caller can override that cycle's inputs.
  task automatic wait_hs(input int n, input string nm);
    int k;
    for (k = 0; k < 60; k++) begin
      edge_drive();
      if (hs_q.size() >= n) break;
      to_neg();
    end
    if (hs_q.size() < n) chk({nm, "_hs_timeout"}, hs_q.size(), n);
  endtask

  task automatic wait_pops(input int n, input string nm);
    for (int k = 0; k < 200 && pop_pc_q.size() < n; k++) cyc();
    if (pop_pc_q.size() < n) chk({nm, "_pop_timeout"}, pop_pc_q.size(), n);
  endtask

  typedef struct {
    logic        req_rdy;
    logic        inst_rdy;
    logic        exp_req_vld;
    logic [31:0] exp_addr;
    logic        exp_inst_vld;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b1; jmp_en = 1'b0; jmp_pc = 32'd0; mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b0; mem_rsp_data = 32'd0; mem_rsp_err = 1'b0; inst_ready = 1'b1;
    err_addr = 32'hFFFF_FFFF;

    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h8000_0000, 1'b1, 32'h8000_0000};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h8000_0004, 1'b1, 32'h8000_0004};
    tbl[7] = '{1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h0};

    // 1: cycle-by-cycle sequential fetch after reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (i > 0) edge_drive();
      mem_req_ready = tbl[i].req_rdy;
      inst_ready    = tbl[i].inst_rdy;
      to_neg();
      chk($sformatf("t1_req_valid[%0d]", i), {31'd0, mem_req_valid}, {31'd0, tbl[i].exp_req_vld});
      chk($sformatf("t1_req_addr[%0d]", i), mem_req_addr, tbl[i].exp_addr);
      chk($sformatf("t1_inst_valid[%0d]", i), {31'd0, inst_valid}, {31'd0, tbl[i].exp_inst_vld});
      if (tbl[i].exp_inst_vld) begin
        chk($sformatf("t1_inst_pc[%0d]", i), inst_pc, tbl[i].exp_pc);
        chk($sformatf("t1_inst[%0d]", i), inst, mdata(tbl[i].exp_pc));
      end
    end

    // 2: IDU stalled -> exactly FIFO_DEPTH requests, then drains in order
    inst_ready = 1'b0;
    do_reset();
    to_neg();
    for (int i = 0; i < 20; i++) cyc();
    chk("t2_req_count", hs_q.size(), 2);
    chk("t2_req_valid_idle", {31'd0, mem_req_valid}, 32'd0);
    inst_ready = 1'b1;
    wait_pops(2, "t2");
    if (pop_pc_q.size() >= 2) begin
      chk("t2_pop0_pc", pop_pc_q[0], 32'h8000_0000);
      chk("t2_pop1_pc", pop_pc_q[1], 32'h8000_0004);
      chk("t2_pop1_inst", pop_inst_q[1], mdata(32'h8000_0004));
    end

    // 3: redirect in WAIT, stale response arrives during DROP
    do_reset();
    wait_hs(1, "t3");
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'd0;
    jmp_en = 1'b1;
    jmp_pc = 32'h8000_0103;
    to_neg();
    chk("t3_no_valid_on_jmp", {31'd0, inst_valid}, 32'd0);
    edge_drive();
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hDEAD_BEEF;
    to_neg();
    chk("t3_stale_not_pushed", {31'd0, inst_valid}, 32'd0);
    wait_pops(1, "t3");
    if (pop_pc_q.size() >= 1) begin
      chk("t3_pop_pc", pop_pc_q[0], 32'h8000_0100);
      chk("t3_pop_inst", pop_inst_q[0], mdata(32'h8000_0100));
    end
    if (hs_q.size() >= 2) chk("t3_next_req", hs_q[1], 32'h8000_0100);

    // 4: redirect coincides with a response while the buffer holds an entry and the IDU is ready
    inst_ready = 1'b0;
    do_reset();
    wait_hs(2, "t4");
    jmp_en = 1'b1;
    jmp_pc = 32'h8000_0200;
    inst_ready = 1'b1;
    to_neg();
    chk("t4_no_valid_on_jmp", {31'd0, inst_valid}, 32'd0);
    cyc();
    chk("t4_flushed", {31'd0, inst_valid}, 32'd0);
    wait_pops(1, "t4");
    if (pop_pc_q.size() >= 1) chk("t4_pop_pc", pop_pc_q[0], 32'h8000_0200);
    if (hs_q.size() >= 3) chk("t4_next_req", hs_q[2], 32'h8000_0200);

    // 5: request held through backpressure, redirect mid-stall
    mem_req_ready = 1'b0;
    do_reset();
    to_neg();
    for (int c = 1; c <= 5; c++) begin
      edge_drive();
      if (c == 2) begin
        jmp_en = 1'b1;
        jmp_pc = 32'h8000_0300;
      end
      to_neg();
      chk($sformatf("t5_req_valid[%0d]", c), {31'd0, mem_req_valid}, 32'd1);
      chk($sformatf("t5_req_addr[%0d]", c), mem_req_addr, 32'h8000_0000);
    end
    edge_drive();
    mem_req_ready = 1'b1;
    to_neg();
    wait_pops(1, "t5");
    if (pop_pc_q.size() >= 1) chk("t5_pop_pc", pop_pc_q[0], 32'h8000_0300);
    if (hs_q.size() >= 2) begin
      chk("t5_req0", hs_q[0], 32'h8000_0000);
      chk("t5_req1", hs_q[1], 32'h8000_0300);
    end

    // 6: access fault on the second fetch
    do_reset();
    err_addr = 32'h8000_0004;
    to_neg();
    wait_pops(3, "t6");
    if (pop_pc_q.size() >= 3) begin
      chk("t6_pop0_err", pop_err_q[0], 32'd0);
      chk("t6_pop1_pc", pop_pc_q[1], 32'h8000_0004);
      chk("t6_pop1_err", pop_err_q[1], 32'd1);
      chk("t6_pop1_inst", pop_inst_q[1], 32'd0);
      chk("t6_pop2_pc", pop_pc_q[2], 32'h8000_0008);
      chk("t6_pop2_err", pop_err_q[2], 32'd0);
      chk("t6_pop2_inst", pop_inst_q[2], mdata(32'h8000_0008));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
